// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl -- PS/2 scan-code sequencer with modifier tracking and event FIFO.
//
// Decodes PS/2 set-2 byte sequences (optional E0 prefix, optional F0 break
// prefix, then the scan code) into events {code, break, ext, mods}. Each
// completed sequence is pushed into a small FIFO; the consumer pops with a
// valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   ps2_data   received scan byte, qualified by ps2_valid
//   ps2_valid  one-cycle strobe per received byte
//   ev_valid   FIFO head holds an event
//   ev_ready   consumer accepts the head event
//   ev_code    head event scan code (prefixes stripped)
//   ev_break   head event is a key release
//   ev_ext     head event carried the E0 prefix
//   ev_mods    head event modifiers {alt, ctrl, shift}
//   overflow   sticky: an event was dropped because the FIFO was full
//   clr_ovf    clears overflow (a same-cycle drop wins)
//   key_cnt    count of release events accepted into the FIFO (wraps)
//
// Build option: define KBD_TYPEMATIC_FILTER_EN to suppress typematic repeats
// of the most recently pressed, not yet released key.

module kbd_event_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_data,
   input  logic       ps2_valid,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_break,
   output logic       ev_ext,
   output logic [2:0] ev_mods,
   output logic       overflow,
   input  logic       clr_ovf,
   output logic [7:0] key_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int EVT_W = 13;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t             state, state_nxt;
   logic               evt_done, evt_brk, evt_ext;
   logic               lshift, rshift, ctrl, alt;
   logic               lshift_nxt, rshift_nxt, ctrl_nxt, alt_nxt;
   logic [2:0]         mods_nxt;
   logic               suppress, push, pop, full, wr_en, ovf_set;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [EVT_W-1:0]   mem [FIFO_DEPTH];
   logic [EVT_W-1:0]   head;

   // Bytes that are protocol responses / errors rather than key data.
   function automatic logic is_discard(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
         default:                                                 is_discard = 1'b0;
      endcase
   endfunction

   // Sequence decode: which event (if any) this byte completes.
   always_comb begin
      state_nxt = state;
      evt_done  = 1'b0;
      evt_brk   = 1'b0;
      evt_ext   = 1'b0;
      if (ps2_valid) begin
         if (is_discard(ps2_data)) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (ps2_data == 8'hE0)      state_nxt = EXT;
                  else if (ps2_data == 8'hF0) state_nxt = BRK;
                  else                        evt_done  = 1'b1;
               end
               EXT: begin
                  if (ps2_data == 8'hF0) begin
                     state_nxt = EXT_BRK;
                  end else begin
                     evt_done  = 1'b1;
                     evt_ext   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
               BRK: begin
                  evt_done  = 1'b1;
                  evt_brk   = 1'b1;
                  state_nxt = IDLE;
               end
               default: begin
                  evt_done  = 1'b1;
                  evt_brk   = 1'b1;
                  evt_ext   = 1'b1;
                  state_nxt = IDLE;
               end
            endcase
         end
      end
   end

   // Modifier update is visible in the event that causes it.
   always_comb begin
      lshift_nxt = lshift;
      rshift_nxt = rshift;
      ctrl_nxt   = ctrl;
      alt_nxt    = alt;
      if (evt_done) begin
         case (ps2_data)
            8'h12:   lshift_nxt = ~evt_brk;
            8'h59:   rshift_nxt = ~evt_brk;
            8'h14:   ctrl_nxt   = ~evt_brk;
            8'h11:   alt_nxt    = ~evt_brk;
            default: ;
         endcase
      end
      mods_nxt = {alt_nxt, ctrl_nxt, lshift_nxt | rshift_nxt};
   end

`ifdef KBD_TYPEMATIC_FILTER_EN
   logic       held_vld;
   logic [7:0] held_code;
   logic       held_ext;
   logic       held_match;

   assign held_match = held_vld && (held_code == ps2_data) && (held_ext == evt_ext);
   assign suppress   = evt_done && !evt_brk && held_match;

   // Track the latest pressed key; its own release forgets it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_vld  <= 1'b0;
         held_code <= 8'h00;
         held_ext  <= 1'b0;
      end else if (evt_done) begin
         if (!evt_brk) begin
            held_vld  <= 1'b1;
            held_code <= ps2_data;
            held_ext  <= evt_ext;
         end else if (held_match) begin
            held_vld  <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign ev_valid = (count != '0);
   assign pop      = ev_valid && ev_ready;
   assign push     = evt_done && !suppress;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en    = push && (!full || pop);
   assign ovf_set  = push && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         lshift   <= 1'b0;
         rshift   <= 1'b0;
         ctrl     <= 1'b0;
         alt      <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         key_cnt  <= 8'h00;
      end else begin
         state  <= state_nxt;
         lshift <= lshift_nxt;
         rshift <= rshift_nxt;
         ctrl   <= ctrl_nxt;
         alt    <= alt_nxt;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         if (wr_en && evt_brk) key_cnt <= key_cnt + 8'd1;
      end
   end

   // Event storage is data only; emptiness is tracked by count.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {ps2_data, evt_brk, evt_ext, mods_nxt};
   end

   // Outputs read zero whenever the FIFO is empty (including in reset).
   assign head     = mem[rd_ptr];
   assign ev_code  = ev_valid ? head[12:5] : 8'h00;
   assign ev_break = ev_valid ? head[4]    : 1'b0;
   assign ev_ext   = ev_valid ? head[3]    : 1'b0;
   assign ev_mods  = ev_valid ? head[2:0]  : 3'b000;

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 ps2_data  in  8  received PS/2 scan byte; valid only while ps2_valid=1.
REQ-005 ps2_valid  in  1  one-cycle strobe per received byte.
REQ-006 ev_valid  out  1  FIFO head holds an event.
REQ-007 ev_ready  in  1  consumer accepts the head event.
REQ-008 ev_code  out  8  head event scan code, without prefix bytes.
REQ-009 ev_break  out  1  head event is a key release.
REQ-010 ev_ext  out  1  head event carried the E0 prefix.
REQ-011 ev_mods  out  3  head event modifiers {alt,ctrl,shift}, sampled after that event's own update.
REQ-012 overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
REQ-013 clr_ovf  in  1  clears overflow.
REQ-014 key_cnt  out  8  count of release events pushed into the FIFO.

Function
REQ-015 The sequencer SHALL have four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0->EXT; F0->BRK; other byte completes a make event, stay IDLE.
- EXT: F0->EXT_BRK; other byte completes an extended make, ->IDLE.
- BRK: any byte completes a break, ->IDLE.
- EXT_BRK: any byte completes an extended break, ->IDLE.
REQ-016 Bytes 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFC, 0xFE and 0xFF SHALL be discarded.
- Such a byte produces no event and forces the FSM to IDLE from any state.
REQ-017 The FSM SHALL advance only on cycles with ps2_valid=1; otherwise it holds state.
REQ-018 Modifier tracking:
- shift = lshift (0x12) OR rshift (0x59), each tracked separately.
- ctrl = 0x14 with or without E0; alt = 0x11 with or without E0.
- Each is set on make and cleared on break.
- The update takes effect in the same cycle the event is pushed.
REQ-019 Every completed sequence, including modifier keys, SHALL push one event {code, break, ext, mods}.
REQ-020 FIFO behaviour:
- Pop when ev_valid AND ev_ready; ev_* outputs come straight from the FIFO head.
- Latency: a byte completing an event at edge N, with the FIFO empty, gives ev_valid=1 after edge N.
REQ-021 Push while full with no pop in the same cycle: the event is dropped and overflow is set to 1.
- Modifier state still updates.
REQ-022 Push and pop in the same cycle SHALL both occur, including when the FIFO is full; count unchanged.
REQ-023 Pop on an empty FIFO is ignored; pointers wrap modulo FIFO_DEPTH.
REQ-024 key_cnt increments by 1 per accepted (pushed) break event and wraps 255->0.
REQ-025 overflow clears on clr_ovf=1; a set condition in the same cycle wins.

Reset
REQ-026 While rst=0, regardless of clk:
- FSM=IDLE; FIFO empty; all modifiers=0.
- ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, ev_mods=0, overflow=0, key_cnt=0.
REQ-027 Reset mid-sequence (e.g. after E0) SHALL discard the partial sequence; the next byte is decoded from IDLE.

Configuration
REQ-028 Macro KBD_TYPEMATIC_FILTER_EN:
- Defined: a make event whose {code,ext} equals the most recent make not yet released is suppressed. No push, no key_cnt change. Modifiers are unaffected.
- The tracked key clears on its matching break and on reset.
- Undefined: every typematic repeat pushes a make event.

Verification
REQ-029 Byte 1C -> one event code=1C break=0 ext=0 mods=000; ev_valid high on the cycle after the strobe.
REQ-030 Bytes 12,1C,F0,1C,F0,12 -> four events:
- (12,mk,mods=001), (1C,mk,001), (1C,brk,001), (12,brk,000).
- key_cnt=2.
REQ-031 Bytes E0,F0,75 -> event code=75 break=1 ext=1.
REQ-032 ev_ready=0, FIFO_DEPTH=4, six makes:
- FIFO holds the first 4; overflow=1.
- Pulsing clr_ovf clears it; popping returns codes in order.
REQ-033 Bytes 1C,1C,1C:
- 3 events without KBD_TYPEMATIC_FILTER_EN; 1 event with it.
- rst=0 after E0, then 74 -> make 74 with ext=0.
